// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // RISC-V canonical NOP (addi x0, x0, 0), the usual bubble for the IF/ID stage.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Entries held in each state. The state encoding equals the count.
  function automatic logic [1:0] occ_of(input state_e s);
    return logic'(s == ONE) ? 2'd1 : ((s == TWO) ? 2'd2 : 2'd0);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter that accepts an increment of 0..3 per cycle.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  // Next count: add the increment with one carry bit, clamp at all-ones.
  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    if (clear) cnt_d = '0;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a valid/ready pipeline stage.
// in_ready is registered so out_ready never reaches the upstream side
// combinationally; the skid entry absorbs the one beat in flight.
//
//   state | meaning
//   EMPTY | nothing held, out_valid low, out_data = BUBBLE
//   ONE   | main holds the head entry
//   TWO   | main holds head, skid holds the next entry, in_ready low
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        drop_inc;
  logic              accept, emit;

  assign occupancy = occ_of(state_q);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  // Next-state and datapath; flush wins over both handshakes. An entry
  // emitted in the flush cycle leaves normally and is not counted as dropped.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_inc = 2'd0;
    if (flush) begin
      state_d  = EMPTY;
      main_d   = BUBBLE;
      skid_d   = BUBBLE;
      drop_inc = occupancy + {1'b0, accept} - {1'b0, emit};
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (emit && !accept) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end else if (accept && emit) begin
            main_d  = in_data;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // State and payload registers; reset discards everything without counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (drop_inc),
    .cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model / scoreboard.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   drop_cnt;
  logic          in_ready_s, out_valid_s;
  logic [DW-1:0] out_data_s;
  logic [1:0]    occupancy_s;
  logic [1:0]    drop_cnt_s;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .BUBBLE(RV_NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .occupancy(occupancy_s), .drop_cnt(drop_cnt_s)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sb[$];
  int            exp_drop   = 0;
  int            exp_drop_s = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model at the negedge,
  // then advance the model by what the coming edge should do.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit ordy,
                     input bit fl, input bit rb);
    bit acc, em;
    int n;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl; rst = rb;
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("out_data", out_data, (sb.size() != 0) ? sb[0] : RV_NOP);
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("drop_cnt_sat", 32'(drop_cnt_s), 32'(exp_drop_s));
    acc = v && (sb.size() < 2);
    em  = ordy && (sb.size() != 0);
    if (!rb) begin
      sb.delete();
      exp_drop   = 0;
      exp_drop_s = 0;
    end else begin
      if (em) chk("emit_order", out_data, sb.pop_front());
      if (fl) begin
        n = sb.size() + int'(acc);
        exp_drop   = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
        exp_drop_s = (exp_drop_s + n > 3) ? 3 : exp_drop_s + n;
        sb.delete();
      end else if (acc) begin
        sb.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then streaming 1..4 with out_ready held high.
    cyc(0, 0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);

    // Stall: load A, stall 3 cycles offering B then C, release.
    cyc(1, 32'hA, 1, 0, 1);
    cyc(1, 32'hB, 0, 0, 1);
    cyc(1, 32'hC, 0, 0, 1);
    cyc(1, 32'hC, 0, 0, 1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head", out_data, 32'hA);
    cyc(1, 32'hC, 1, 0, 1);
    cyc(1, 32'hC, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);

    // Flush in TWO with nothing incoming: two entries dropped.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h11, 0, 0, 1);
    cyc(1, 32'h22, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk("flush_two_drop", 32'(drop_cnt), 32'd2);
    chk("flush_two_bubble", out_data, RV_NOP);
    chk("flush_two_ready", 32'(in_ready), 32'd1);

    // Flush in ONE while emitting and accepting: only the incoming one counts.
    cyc(1, 32'h33, 1, 0, 1);
    cyc(1, 32'h44, 1, 1, 1);
    chk("flush_emit_drop", 32'(drop_cnt), 32'd3);
    chk("flush_emit_valid", 32'(out_valid), 32'd0);
    cyc(0, 0, 1, 0, 1);

    // Saturation: four flushes in TWO on the 2-bit counter.
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, DW'(32'h100 + k), 0, 0, 1);
      cyc(1, DW'(32'h200 + k), 0, 0, 1);
      cyc(0, 0, 0, 1, 1);
    end
    chk("sat_value", 32'(drop_cnt_s), 32'd3);
    chk("sat_wide", 32'(drop_cnt), 32'd8);
    cyc(0, 0, 0, 0, 1);

    // Reset together with flush while in TWO.
    cyc(1, 32'h55, 0, 0, 1);
    cyc(1, 32'h66, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("rst_flush_drop", 32'(drop_cnt), 32'd0);
    chk("rst_flush_occ", 32'(occupancy), 32'd0);
    chk("rst_flush_ready", 32'(in_ready), 32'd1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), DW'($urandom), bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 19) == 0), 1);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
